// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// A start/busy/done handshake frames each WIDTH+1 cycle operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_load;
  logic             w_busy;
  logic             w_done;

  // Full-adder cell on the current LSBs.
  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: the shift registers are few enough to be plain flops, so they are
  // reset along with the control state; an aborted add leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= A;
      r_b_sh  <= B;
      r_carry <= Cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_s_sh  <= {w_s, r_s_sh[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      // Result registers only move on the final bit, so they hold between adds.
      if (w_last) begin
        r_sum  <= {w_s, r_s_sh[WIDTH-1:1]};
        r_cout <= w_c;
      end
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule
